// File: rtl/cache_dm_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_dm_param
// Description : Parametrised direct-mapped, write-through, write-allocate
//               byte cache between a CPU request port (4-phase handshake) and
//               a backing-memory port. One outstanding request at a time.
//               Strobed invalidate port accepted in every state.
//               Optional macro CACHE_STATS_EN adds saturating hit_count and
//               miss_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_dm_param #(
    parameter int ADDR_W     = 16,
    parameter int LINE_BYTES = 2,
    parameter int NUM_LINES  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W+8:0]       cpu_request,
    input  logic                    cpu_request_ready,
    input  logic                    invalidate_valid,
    input  logic [ADDR_W-1:0]       invalidate_address,
    output logic [ADDR_W+8:0]       memory_request,
    output logic                    memory_request_ready,
    input  logic [LINE_BYTES*8-1:0] memory_response,
    input  logic                    memory_response_ready,
    output logic [7:0]              data_out,
    output logic                    data_out_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
`endif
);

    localparam int c_OFFSET_W = $clog2(LINE_BYTES);
    localparam int c_INDEX_W  = $clog2(NUM_LINES);
    localparam int c_TAG_W    = ADDR_W - c_INDEX_W - c_OFFSET_W;
    localparam int c_LINE_W   = LINE_BYTES * 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOOKUP   = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_W+8:0]       r_req;
    logic [NUM_LINES-1:0]    r_valid;
    logic [c_TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [c_LINE_W-1:0]     r_data [NUM_LINES];

    // Fields of the captured request
    logic [ADDR_W-1:0]       w_addr;
    logic                    w_write;
    logic [c_TAG_W-1:0]      w_tag;
    logic [c_INDEX_W-1:0]    w_idx;
    logic [c_OFFSET_W-1:0]   w_off;
    logic [c_LINE_W-1:0]     w_line;
    logic [7:0]              w_hit_byte;
    logic [7:0]              w_resp_byte;
    logic                    w_lookup_hit;
    logic                    w_read_hit;
    logic                    w_fill;

    // Fields of the invalidate address
    logic [c_TAG_W-1:0]      w_inv_tag;
    logic [c_INDEX_W-1:0]    w_inv_idx;
    logic                    w_inv_match;

    assign w_addr      = r_req[ADDR_W-1:0];
    assign w_write     = r_req[ADDR_W+8];
    assign w_tag       = w_addr[ADDR_W-1:c_INDEX_W+c_OFFSET_W];
    assign w_idx       = w_addr[c_INDEX_W+c_OFFSET_W-1:c_OFFSET_W];
    assign w_off       = w_addr[c_OFFSET_W-1:0];
    assign w_line      = r_data[w_idx];
    assign w_hit_byte  = w_line[{w_off, 3'b000} +: 8];
    assign w_resp_byte = memory_response[{w_off, 3'b000} +: 8];

    assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_read_hit   = w_lookup_hit && !w_write;
    assign w_fill       = (r_state == S_MEM_WAIT) && memory_response_ready;

    assign w_inv_tag = invalidate_address[ADDR_W-1:c_INDEX_W+c_OFFSET_W];
    assign w_inv_idx = invalidate_address[c_INDEX_W+c_OFFSET_W-1:c_OFFSET_W];

    // An invalidate racing a fill of the same index must compare against the
    // tag being written this cycle, not the outgoing one.
    assign w_inv_match = (w_fill && (w_inv_idx == w_idx))
                       ? (w_inv_tag == w_tag)
                       : (r_valid[w_inv_idx] && (r_tag[w_inv_idx] == w_inv_tag));

    // Request FSM with registered memory-side and CPU-side outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= S_IDLE;
            r_req                <= '0;
            memory_request       <= '0;
            memory_request_ready <= 1'b0;
            data_out             <= 8'h00;
            data_out_ready       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_request_ready) begin
                        r_req   <= cpu_request;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_read_hit) begin
                        data_out       <= w_hit_byte;
                        data_out_ready <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        // Read miss, or any write (write-through)
                        memory_request       <= r_req;
                        memory_request_ready <= 1'b1;
                        r_state              <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (memory_response_ready) begin
                        data_out             <= w_resp_byte;
                        data_out_ready       <= 1'b1;
                        memory_request_ready <= 1'b0;
                        r_state              <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!cpu_request_ready) begin
                        data_out_ready <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Valid bits: set by a fill, cleared by a matching invalidate (which wins)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (invalidate_valid && w_inv_match) begin
                r_valid[w_inv_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays; contents are meaningless while the valid bit is 0
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_data[w_idx] <= memory_response;
            r_tag[w_idx]  <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, sampled at the lookup decision
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else if (r_state == S_LOOKUP) begin
            if (w_read_hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'h0001;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'h0001;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
